// File: rtl/fetch_pkg.sv
// Shared types and default geometry for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic {
        S_FIRST  = 1'b0,
        S_SECOND = 1'b1
    } fetch_state_e;

    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_ADDR_W    = 20;
    localparam int unsigned DEF_RESET_PC  = 32;
    localparam int unsigned DEF_LONG_BIT  = 15;
    localparam int unsigned DEF_ISSUE_GAP = 5;

endpackage

// File: rtl/instr_mem.sv
// Word-addressed instruction store: combinational read, registered write.
// Not cleared by reset; a same-cycle read of a written address returns the old word.
module instr_mem
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one/two-word assembly FSM and valid/ready output register.
// Define FETCH_ISSUE_GAP_EN to pace issues with ISSUE_GAP idle cycles after every advance.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned RESET_PC  = DEF_RESET_PC,
    parameter int unsigned LONG_BIT  = DEF_LONG_BIT,
    parameter int unsigned ISSUE_GAP = DEF_ISSUE_GAP
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_redirect_valid,
    input  logic [ADDR_W-1:0]   i_redirect_pc,
    input  logic                i_mem_we,
    input  logic [ADDR_W-1:0]   i_mem_waddr,
    input  logic [DATA_W-1:0]   i_mem_wdata,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [2*DATA_W-1:0] o_out_instr,
    output logic                o_out_long,
    output logic [ADDR_W-1:0]   o_out_pc
);

    fetch_state_e        r_state, w_state_next;
    logic [ADDR_W-1:0]   r_pc, w_pc_next, w_pc_inc;
    logic [ADDR_W-1:0]   r_hold_pc, w_hold_pc_next;
    logic [DATA_W-1:0]   r_hold, w_hold_next;
    logic [DATA_W-1:0]   w_word;
    logic                r_out_valid, w_out_valid_next;
    logic [2*DATA_W-1:0] r_out_instr, w_out_instr_next;
    logic                r_out_long, w_out_long_next;
    logic [ADDR_W-1:0]   r_out_pc, w_out_pc_next;
    logic                w_advance;
    logic                w_gap_busy;

    instr_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_instr_mem (
        .clk     (clk),
        .i_we    (i_mem_we),
        .i_waddr (i_mem_waddr),
        .i_wdata (i_mem_wdata),
        .i_raddr (r_pc),
        .o_rdata (w_word)
    );

    assign w_pc_inc = r_pc + ADDR_W'(1);

`ifdef FETCH_ISSUE_GAP_EN
    localparam int unsigned GAP_W = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;

    logic [GAP_W-1:0] r_gap;

    assign w_gap_busy = (r_gap != '0);

    always_ff @(posedge clk) begin
        if (reset || i_redirect_valid) begin
            r_gap <= '0;
        end else if (w_advance) begin
            r_gap <= GAP_W'(ISSUE_GAP);
        end else if (w_gap_busy) begin
            r_gap <= r_gap - GAP_W'(1);
        end
    end
`else
    logic w_unused_gap;

    assign w_unused_gap = ^ISSUE_GAP;
    assign w_gap_busy   = 1'b0;
`endif

    assign w_advance = (!r_out_valid || i_out_ready) && !w_gap_busy;

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_hold_next      = r_hold;
        w_hold_pc_next   = r_hold_pc;
        // A consumed output drops unless something new is loaded behind it
        w_out_valid_next = r_out_valid && !i_out_ready;
        w_out_instr_next = r_out_instr;
        w_out_long_next  = r_out_long;
        w_out_pc_next    = r_out_pc;

        if (i_redirect_valid) begin
            w_pc_next        = i_redirect_pc;
            w_state_next     = S_FIRST;
            w_out_valid_next = 1'b0;
        end else if (w_advance) begin
            w_pc_next = w_pc_inc;
            unique case (r_state)
                S_FIRST: begin
                    if (w_word[LONG_BIT]) begin
                        w_hold_next      = w_word;
                        w_hold_pc_next   = r_pc;
                        w_state_next     = S_SECOND;
                        w_out_valid_next = 1'b0;
                    end else begin
                        w_out_instr_next = {w_word, {DATA_W{1'b0}}};
                        w_out_long_next  = 1'b0;
                        w_out_pc_next    = r_pc;
                        w_out_valid_next = 1'b1;
                    end
                end
                S_SECOND: begin
                    w_out_instr_next = {r_hold, w_word};
                    w_out_long_next  = 1'b1;
                    w_out_pc_next    = r_hold_pc;
                    w_out_valid_next = 1'b1;
                    w_state_next     = S_FIRST;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FIRST;
            r_pc        <= ADDR_W'(RESET_PC);
            r_hold      <= '0;
            r_hold_pc   <= '0;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_long  <= 1'b0;
            r_out_pc    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_hold      <= w_hold_next;
            r_hold_pc   <= w_hold_pc_next;
            r_out_valid <= w_out_valid_next;
            r_out_instr <= w_out_instr_next;
            r_out_long  <= w_out_long_next;
            r_out_pc    <= w_out_pc_next;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_instr = r_out_instr;
    assign o_out_long  = r_out_long;
    assign o_out_pc    = r_out_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed timing cases plus a randomized run
// scored against an instruction-level model of the fetched program.
module tb_fetch_unit;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned RESET_PC  = 32;
    localparam int unsigned LONG_BIT  = 15;
    localparam int unsigned ISSUE_GAP = 5;
`ifdef FETCH_ISSUE_GAP_EN
    localparam int SP = ISSUE_GAP + 1;
`else
    localparam int SP = 1;
`endif
    // Stall of 3 cycles overlaps the pacing gap when enabled
    localparam int STALL_LAT = (SP > 4) ? SP - 3 : 1;

    logic                clk;
    logic                reset;
    logic                i_redirect_valid;
    logic [ADDR_W-1:0]   i_redirect_pc;
    logic                i_mem_we;
    logic [ADDR_W-1:0]   i_mem_waddr;
    logic [DATA_W-1:0]   i_mem_wdata;
    logic                o_out_valid;
    logic                i_out_ready;
    logic [2*DATA_W-1:0] o_out_instr;
    logic                o_out_long;
    logic [ADDR_W-1:0]   o_out_pc;

    fetch_unit #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .RESET_PC  (RESET_PC),
        .LONG_BIT  (LONG_BIT),
        .ISSUE_GAP (ISSUE_GAP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .i_mem_we         (i_mem_we),
        .i_mem_waddr      (i_mem_waddr),
        .i_mem_wdata      (i_mem_wdata),
        .o_out_valid      (o_out_valid),
        .i_out_ready      (i_out_ready),
        .o_out_instr      (o_out_instr),
        .o_out_long       (o_out_long),
        .o_out_pc         (o_out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] m_mem [256];
    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] m_instr(input logic [7:0] pc);
        logic [7:0] nxt;
        nxt = pc + 8'd1;
        if (m_mem[pc][LONG_BIT]) return {m_mem[pc], m_mem[nxt]};
        return {m_mem[pc], 16'h0000};
    endfunction

    function automatic logic [7:0] m_next_pc(input logic [7:0] pc);
        return m_mem[pc][LONG_BIT] ? pc + 8'd2 : pc + 8'd1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] addr, input logic [15:0] data);
        i_mem_we    = 1'b1;
        i_mem_waddr = addr;
        i_mem_wdata = data;
        tick();
        i_mem_we    = 1'b0;
        m_mem[addr] = data;
    endtask

    task automatic redirect_to(input logic [7:0] pc);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = pc;
        tick();
        i_redirect_valid = 1'b0;
        chk("redir_drop", o_out_valid, 0);
    endtask

    task automatic expect_next(input string tag, input logic [7:0] pc, input logic [31:0] instr,
                               input logic lng, input int lat);
        int n;
        n = 0;
        i_out_ready      = 1'b1;
        i_redirect_valid = 1'b0;
        do begin
            tick();
            n++;
        end while (!o_out_valid && n < 64);
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_pc"}, o_out_pc, pc);
        chk({tag, "_instr"}, o_out_instr, instr);
        chk({tag, "_long"}, o_out_long, lng);
    endtask

    initial begin
        logic [7:0]  exp_pc;
        logic [7:0]  tgt;
        logic [15:0] w;
        logic        rdy;
        logic        redir;
        logic        redir_prev;
        int          since;

        reset            = 1'b1;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        i_mem_we         = 1'b0;
        i_mem_waddr      = '0;
        i_mem_wdata      = '0;
        i_out_ready      = 1'b0;
        tick();
        tick();
        chk("rst_valid", o_out_valid, 0);
        chk("rst_instr", o_out_instr, 0);
        chk("rst_long", o_out_long, 0);
        chk("rst_pc", o_out_pc, 0);

        // Program load under reset for all directed cases
        load(8'd32, 16'h0001);
        load(8'd33, 16'h0002);
        load(8'd34, 16'h0003);
        for (int i = 0; i < 6; i++) load(8'(40 + i), 16'(16'h0100 + i));
        load(8'd50, 16'h8001);
        load(8'd51, 16'h2222);
        load(8'd100, 16'h0042);
        load(8'd60, 16'h0011);
        load(8'd255, 16'h8123);
        load(8'd0, 16'h4567);
        load(8'd1, 16'h0009);

        // Short stream from reset
        reset = 1'b0;
        expect_next("short0", 8'd32, 32'h0001_0000, 1'b0, 1);
        expect_next("short1", 8'd33, 32'h0002_0000, 1'b0, SP);
        expect_next("short2", 8'd34, 32'h0003_0000, 1'b0, SP);

        // Long instruction from reset; other memory contents survive the reset
        reset = 1'b1;
        load(8'd32, 16'h8005);
        load(8'd33, 16'h1234);
        load(8'd34, 16'h0007);
        reset = 1'b0;
        expect_next("long0", 8'd32, 32'h8005_1234, 1'b1, 1 + SP);
        expect_next("long_next", 8'd34, 32'h0007_0000, 1'b0, SP);

        // Back-pressure
        redirect_to(8'd40);
        expect_next("bp0", 8'd40, 32'h0100_0000, 1'b0, 1);
        i_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", o_out_valid, 1);
            chk("bp_hold_pc", o_out_pc, 40);
            chk("bp_hold_instr", o_out_instr, 32'h0100_0000);
        end
        expect_next("bp_release", 8'd41, 32'h0101_0000, 1'b0, STALL_LAT);

        // Redirect while the second word of a long instruction is pending
        redirect_to(8'd50);
        tick();
        chk("mid_long_valid", o_out_valid, 0);
        redirect_to(8'd100);
        expect_next("mid_long_tgt", 8'd100, 32'h0042_0000, 1'b0, 1);

        // Write to the address being fetched in the same cycle yields the old word
        redirect_to(8'd60);
        i_mem_we    = 1'b1;
        i_mem_waddr = 8'd60;
        i_mem_wdata = 16'h0022;
        i_out_ready = 1'b1;
        tick();
        i_mem_we = 1'b0;
        chk("rdw_valid", o_out_valid, 1);
        chk("rdw_old", o_out_instr, 32'h0011_0000);
        m_mem[60] = 16'h0022;
        redirect_to(8'd60);
        expect_next("rdw_new", 8'd60, 32'h0022_0000, 1'b0, 1);

        // Long instruction at the top address wraps to address 0 for its second word
        redirect_to(8'd255);
        expect_next("wrap", 8'd255, 32'h8123_4567, 1'b1, 1 + SP);
        expect_next("wrap_next", 8'd1, 32'h0009_0000, 1'b0, SP);

        // Random program, reset overriding a simultaneous redirect
        reset       = 1'b1;
        i_out_ready = 1'b0;
        for (int a = 0; a < 256; a++) begin
            w = 16'($urandom);
            w[LONG_BIT] = ($urandom_range(2) == 0);
            load(8'(a), w);
        end
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 8'd77;
        tick();
        i_redirect_valid = 1'b0;
        chk("rst2_valid", o_out_valid, 0);
        chk("rst2_instr", o_out_instr, 0);
        chk("rst2_pc", o_out_pc, 0);
        reset = 1'b0;

        exp_pc     = 8'(RESET_PC);
        redir_prev = 1'b0;
        since      = 0;
        for (int c = 0; c < 3000; c++) begin
            if (redir_prev) chk("rnd_redir_drop", o_out_valid, 0);
            if (o_out_valid) begin
                chk("rnd_pc", o_out_pc, exp_pc);
                chk("rnd_instr", o_out_instr, m_instr(exp_pc));
                chk("rnd_long", o_out_long, m_mem[exp_pc][LONG_BIT]);
            end
            rdy   = ($urandom_range(3) != 0);
            redir = ($urandom_range(40) == 0);
            tgt   = 8'($urandom_range(255));
            if (o_out_valid && rdy) begin
                exp_pc = m_next_pc(exp_pc);
                since  = 0;
            end else begin
                since++;
            end
            if (redir) begin
                exp_pc = tgt;
                since  = 0;
            end
            if (since > 64) begin
                chk("rnd_liveness", since, 64);
                since = 0;
            end
            i_out_ready      = rdy;
            i_redirect_valid = redir;
            i_redirect_pc    = tgt;
            redir_prev       = redir;
            tick();
        end
        i_redirect_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
